// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared FSM encoding and counter-width helper for the serial bubble sorter
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Width of the j/pass counters: $clog2(n), never less than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/compare_swap.sv
// rtl/compare_swap.sv - combinational compare-and-swap of one adjacent pair
// Ports:
//   a, b  in  W  pair under test (a is the lower index)
//   lo    out W  smaller word (a when equal, keeping the sort stable)
//   hi    out W  larger word
//   swap  out 1  a > b, unsigned and strict
module compare_swap #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swap
);

    always_comb begin
        swap = (a > b);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// rtl/bubble_sort_ctrl.sv - serial bubble sorter: one compare per clock, pass by pass, early exit
// Ports:
//   clk    in  1    rising-edge clock
//   rst    in  1    synchronous active-high reset; aborts a sort without a done pulse
//   start  in  1    request, sampled only in IDLE
//   din    in  N*W  element k at din[k*W +: W], captured on the accepting edge
//   busy   out 1    high from the accept edge until the done edge
//   done   out 1    one-cycle pulse, dout valid while it is high
//   dout   out N*W  ascending result (element 0 smallest), held until the next done
module bubble_sort_ctrl
    import sort_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*W-1:0] din,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] dout
);

    localparam int IW = idx_w(N);

    state_e                  state_q, state_d;
    logic [N-1:0][W-1:0]     arr_q, arr_d;
    logic [IW-1:0]           j_q, j_d;
    logic [IW-1:0]           pass_q, pass_d;
    logic                    swapped_q, swapped_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [N*W-1:0]          dout_q, dout_d;

    logic [W-1:0]            cs_lo, cs_hi;
    logic                    cs_swap;
    logic [IW-1:0]           j_next_idx;
    logic [IW-1:0]           j_last;
    logic                    last_pass;
    logic                    swapped_now;

    // j never exceeds N-2, so j+1 always fits the counter width.
    assign j_next_idx = j_q + IW'(1);
    // Each pass bubbles one more maximum into place, shortening the next pass.
    assign j_last     = IW'(N - 2) - pass_q;
    assign last_pass  = (pass_q == IW'(N - 2));

    compare_swap #(.W(W)) u_cs (
        .a    (arr_q[j_q]),
        .b    (arr_q[j_next_idx]),
        .lo   (cs_lo),
        .hi   (cs_hi),
        .swap (cs_swap)
    );

    always_comb begin
        state_d     = state_q;
        arr_d       = arr_q;
        j_d         = j_q;
        pass_d      = pass_q;
        swapped_d   = swapped_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dout_d      = dout_q;
        swapped_now = swapped_q | cs_swap;

        case (state_q)
            IDLE: begin
                if (start) begin
                    arr_d     = din;
                    j_d       = '0;
                    pass_d    = '0;
                    swapped_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                // lo/hi equal the inputs when no swap is needed, so always write back.
                arr_d[j_q]        = cs_lo;
                arr_d[j_next_idx] = cs_hi;
                if (j_q < j_last) begin
                    j_d       = j_q + IW'(1);
                    swapped_d = swapped_now;
                end else if (!swapped_now || last_pass) begin
                    state_d = FINISH;
                end else begin
                    pass_d    = pass_q + IW'(1);
                    j_d       = '0;
                    swapped_d = 1'b0;
                end
            end
            FINISH: begin
                dout_d  = arr_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            arr_q     <= '0;
            j_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            arr_q     <= arr_d;
            j_q       <= j_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dout_q    <= dout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// tb/tb_bubble_sort_ctrl.sv - directed self-checking bench for bubble_sort_ctrl (N=4, W=2)
module tb_bubble_sort_ctrl;

    localparam int N = 4;
    localparam int W = 2;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N*W-1:0] din;
    logic           busy;
    logic           done;
    logic [N*W-1:0] dout;

    int n_cmp;
    int n_err;

    bubble_sort_ctrl #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Element 0 first, matching din[k*W +: W].
    function automatic logic [7:0] p4(input logic [1:0] e0, input logic [1:0] e1,
                                      input logic [1:0] e2, input logic [1:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sort, optionally change din after the accept edge, and check
    // latency (cycles from E0 to done = C+1), busy duration, result and pulse width.
    task automatic run_sort(input logic [7:0] d, input logic [7:0] d_after,
                            input logic [7:0] exp, input int exp_k, input string name);
        int k;
        int busy_cnt;
        din   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        din   = d_after;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end
        busy_cnt = 1;
        k = 0;
        while (done !== 1'b1 && k <= 60) begin
            tick();
            k++;
            if (busy === 1'b1) busy_cnt++;
        end
        n_cmp++;
        if (k !== exp_k) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, k, exp_k);
        end
        n_cmp++;
        if (dout !== exp) begin
            n_err++;
            $display("FAIL %s dout: got %h want %h", name, dout, exp);
        end
        n_cmp++;
        if (busy_cnt !== exp_k) begin
            n_err++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_k);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b dout=%h want 0 0 00", busy, done, dout);
        end
    endtask

    task automatic test_sort_patterns();
        run_sort(p4(3, 2, 0, 1), p4(3, 2, 0, 1), p4(0, 1, 2, 3), 7, "worst_3201");
        run_sort(p4(0, 1, 2, 3), p4(0, 1, 2, 3), p4(0, 1, 2, 3), 4, "sorted_early_exit");
        run_sort(p4(2, 2, 2, 2), p4(2, 2, 2, 2), p4(2, 2, 2, 2), 4, "all_equal");
        run_sort(p4(3, 3, 0, 0), p4(3, 3, 0, 0), p4(0, 0, 3, 3), 7, "dups_3300");
    endtask

    task automatic test_start_held();
        int k;
        din   = p4(1, 0, 3, 2);
        start = 1'b1;
        tick();
        k = 0;
        while (done !== 1'b1 && k <= 60) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k !== 6) begin
            n_err++;
            $display("FAIL held_latency: got %0d want 6", k);
        end
        n_cmp++;
        if (dout !== p4(0, 1, 2, 3) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL held_result: got dout=%h busy=%b want %h 0", dout, busy, p4(0, 1, 2, 3));
        end
        // start still high: the edge after done is the second accept.
        tick();
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL held_reaccept: got busy=%b done=%b want 1 0", busy, done);
        end
        k = 0;
        while (done !== 1'b1 && k <= 60) begin
            start = ~start;
            tick();
            k++;
        end
        start = 1'b0;
        n_cmp++;
        if (k !== 6 || dout !== p4(0, 1, 2, 3)) begin
            n_err++;
            $display("FAIL toggle_midsort: got k=%0d dout=%h want 6 %h", k, dout, p4(0, 1, 2, 3));
        end
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL no_spurious_accept: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_midsort();
        bit seen_done;
        din   = p4(3, 2, 1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00) begin
            n_err++;
            $display("FAIL reset_midsort: got busy=%b done=%b dout=%h want 0 0 00", busy, done, dout);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_done: got activity=1 want 0");
        end
        run_sort(p4(3, 2, 1, 0), p4(3, 2, 1, 0), p4(0, 1, 2, 3), 7, "after_reset_3210");
    endtask

    task automatic test_din_change();
        run_sort(p4(2, 3, 1, 0), p4(0, 0, 0, 0), p4(0, 1, 2, 3), 7, "din_change");
        din = p4(3, 3, 3, 3);
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (dout !== p4(0, 1, 2, 3) || done !== 1'b0) begin
            n_err++;
            $display("FAIL dout_hold: got dout=%h done=%b want %h 0", dout, done, p4(0, 1, 2, 3));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_sort_patterns();
        test_start_held();
        test_reset_midsort();
        test_din_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
